// File: rtl/dma_if.sv
// dma_if: DMA subsystem bundle; slave = dma_top (takes mode_* commands, drives buses, strobes and observed state), master = driver
interface dma_if;
  logic [2:0] mode_processor;
  logic [1:0] mode_io, mode_io2;
  logic [7:0] A, B, C, DB, AB, data_reg, data, src_reg, dest_reg, cnt_reg, word_count, address_sent_to_io;
  logic read_io, read_memory, Enable_memory, Enable_IO1, Enable_IO2;
  logic DREQ1, DACK1, DREQ2, DACK2, HREQ, HACK, dma, cs, mem_op, MemToMem;
  modport slave (
    input mode_processor, mode_io, mode_io2,
    output A, B, C, DB, AB, data_reg, data, src_reg, dest_reg, cnt_reg, word_count, address_sent_to_io,
    output read_io, read_memory, Enable_memory, Enable_IO1, Enable_IO2,
    output DREQ1, DACK1, DREQ2, DACK2, HREQ, HACK, dma, cs, mem_op, MemToMem
  );
  modport master (
    output mode_processor, mode_io, mode_io2,
    input A, B, C, DB, AB, data_reg, data, src_reg, dest_reg, cnt_reg, word_count, address_sent_to_io,
    input read_io, read_memory, Enable_memory, Enable_IO1, Enable_IO2,
    input DREQ1, DACK1, DREQ2, DACK2, HREQ, HACK, dma, cs, mem_op, MemToMem
  );
endinterface

// File: rtl/dma_top.sv
// dma_top: ALU + 8-bit DMA controller + 256x8 memory + two 16x8 IO buffers on shared DB/AB; clk, async rst_n, bus (dma_if.slave)
module dma_top (
  input logic clk,
  input logic rst_n,
  dma_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PROG, REQ, RD, WR, DONE} state_t;
  function automatic logic [255:0][7:0] init_mem();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'(i);
  endfunction
  function automatic logic [15:0][7:0] init_buf(input logic [7:0] base);
    for (int i = 0; i < 16; i++) init_buf[i] = base + 8'(i);
  endfunction
  localparam logic [255:0][7:0] MEM_INIT = init_mem();
  localparam logic [15:0][7:0] BUF1_INIT = init_buf(8'hA0);
  localparam logic [15:0][7:0] BUF2_INIT = init_buf(8'hB0);
  state_t state_q;
  logic [255:0][7:0] mem_q;
  logic [15:0][7:0] buf1_q, buf2_q;
  logic [7:0] src_q, dst_q, cnt_q, wc_q, dreg_q, data_q, c_q, aio_q;
  logic sio_q, dio_q, dev2_q, m2m_q, cs_q, hreq_q, hack_q, dreq1_q, dreq2_q, dack1_q, dack2_q;
  logic [2:0] mp_q;
  logic mi_q, mi2_q;
  logic acc1, acc2, accp, go, rd, wr, io_acc, en_mem, sio_d, dio_d, dev2_d;
  logic [1:0] m;
  logic [7:0] src_d, dst_d, ab_d, db_d, src_word, aio_d, alu_d;
  always_comb begin
    acc1 = mi_q & ~bus.mode_io[1];
    acc2 = mi2_q & ~bus.mode_io2[1];
    accp = &mp_q & bus.mode_processor[2] & ~&bus.mode_processor[1:0];
    go = state_q == IDLE && (acc1 || acc2 || accp);
    // task shape: 0 mem->mem, 1 IO->mem, 2 mem->IO; device requests map onto the processor encoding
    m = acc1 ? (bus.mode_io[0] ? 2'd2 : 2'd1) : acc2 ? (bus.mode_io2[0] ? 2'd2 : 2'd1) : bus.mode_processor[1:0];
    sio_d = m == 2'd1;
    dio_d = m == 2'd2;
    dev2_d = ~acc1 & acc2;
    src_d = sio_d ? 8'h00 : acc1 ? 8'h50 : acc2 ? 8'h58 : 8'h10;
    dst_d = dio_d ? 8'h00 : acc1 ? 8'h30 : acc2 ? 8'h38 : m == 2'd0 ? 8'h40 : 8'h20;
    rd = state_q == RD;
    wr = state_q == WR;
    src_word = sio_q ? (dev2_q ? buf2_q[src_q[3:0]] : buf1_q[src_q[3:0]]) : mem_q[src_q];
    ab_d = rd ? src_q : wr ? dst_q : 8'h00;
    db_d = rd ? src_word : wr ? dreg_q : 8'h00;
    io_acc = rd & sio_q | wr & dio_q;
    en_mem = rd & ~sio_q | wr & ~dio_q;
    aio_d = io_acc ? ab_d : aio_q;
    alu_d = bus.mode_processor[1] ? (bus.mode_processor[0] ? 8'h05 | 8'h03 : 8'h05 & 8'h03)
                                  : (bus.mode_processor[0] ? 8'h05 - 8'h03 : 8'h05 + 8'h03);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mem_q <= MEM_INIT;
      buf1_q <= BUF1_INIT;
      buf2_q <= BUF2_INIT;
      {src_q, dst_q, cnt_q, wc_q, dreg_q, data_q, c_q, aio_q} <= '0;
      {sio_q, dio_q, dev2_q, m2m_q, cs_q, hreq_q, hack_q, dreq1_q, dreq2_q, dack1_q, dack2_q} <= '0;
      mp_q <= 3'b111;
      mi_q <= 1'b1;
      mi2_q <= 1'b1;
    end else begin
      mp_q <= bus.mode_processor;
      mi_q <= bus.mode_io[1];
      mi2_q <= bus.mode_io2[1];
      hack_q <= hreq_q;
      aio_q <= aio_d;
      if (!hack_q && !bus.mode_processor[2]) c_q <= alu_d;
      case (state_q)
        IDLE: if (go) begin
          state_q <= PROG;
          cs_q <= 1'b1;
          src_q <= src_d;
          dst_q <= dst_d;
          cnt_q <= 8'd4;
          wc_q <= 8'd0;
          sio_q <= sio_d;
          dio_q <= dio_d;
          dev2_q <= dev2_d;
          m2m_q <= ~acc1 & ~acc2 & (m == 2'd0);
          dreq1_q <= acc1;
          dreq2_q <= dev2_d;
        end
        PROG: begin
          state_q <= REQ;
          cs_q <= 1'b0;
          hreq_q <= 1'b1;
        end
        REQ: if (hack_q) begin
          state_q <= RD;
          dack1_q <= dreq1_q;
          dack2_q <= dreq2_q;
        end
        RD: begin
          state_q <= WR;
          dreg_q <= db_d;
        end
        WR: begin
          if (!dio_q) mem_q[dst_q] <= dreg_q;
          else if (dev2_q) buf2_q[dst_q[3:0]] <= dreg_q;
          else buf1_q[dst_q[3:0]] <= dreg_q;
          data_q <= dreg_q;
          src_q <= src_q + 8'd1;
          dst_q <= dst_q + 8'd1;
          cnt_q <= cnt_q - 8'd1;
          wc_q <= wc_q + 8'd1;
          if (cnt_q > 8'd1) state_q <= RD;
          else begin
            state_q <= DONE;
            {hreq_q, dack1_q, dack2_q, dreq1_q, dreq2_q, m2m_q} <= '0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.A = 8'h05;
  assign bus.B = 8'h03;
  assign bus.C = c_q;
  assign bus.DB = db_d;
  assign bus.AB = ab_d;
  assign bus.data_reg = dreg_q;
  assign bus.data = data_q;
  assign bus.src_reg = src_q;
  assign bus.dest_reg = dst_q;
  assign bus.cnt_reg = cnt_q;
  assign bus.word_count = wc_q;
  assign bus.address_sent_to_io = aio_d;
  assign bus.read_io = rd & sio_q;
  assign bus.read_memory = rd & ~sio_q;
  assign bus.Enable_memory = en_mem;
  assign bus.mem_op = en_mem;
  assign bus.Enable_IO1 = io_acc & ~dev2_q;
  assign bus.Enable_IO2 = io_acc & dev2_q;
  assign bus.DREQ1 = dreq1_q;
  assign bus.DACK1 = dack1_q;
  assign bus.DREQ2 = dreq2_q;
  assign bus.DACK2 = dack2_q;
  assign bus.HREQ = hreq_q;
  assign bus.HACK = hack_q;
  assign bus.dma = hack_q;
  assign bus.cs = cs_q;
  assign bus.MemToMem = m2m_q;
endmodule

// File: tb/tb_dma_top.sv
// tb_dma_top: scoreboard bench for dma_top; expected write cycles queued at stimulus, popped by a bus monitor
module tb_dma_top;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dma_if bus();
  dma_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {logic [1:0] dev; logic [7:0] ab; logic [7:0] db;} wr_t;
  wr_t exp_q[$];
  wr_t got, e;
  int tests = 0;
  int fails = 0;
  logic rdio_seen, dack1_seen, dack2_seen;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [1:0] d, input logic [7:0] ab0, input logic [7:0] db0);
    for (int i = 0; i < 4; i++) exp_q.push_back('{dev: d, ab: ab0 + 8'(i), db: db0 + 8'(i)});
  endtask
  task automatic wait_done(input string n, input int exp_n);
    int k = 0;
    rdio_seen = 1'b0;
    dack1_seen = 1'b0;
    dack2_seen = 1'b0;
    while (bus.HREQ && k < 40) begin
      cyc(1);
      k++;
      rdio_seen |= bus.read_io;
      dack1_seen |= bus.DACK1;
      dack2_seen |= bus.DACK2;
    end
    chk(n, k, exp_n);
  endtask
  function automatic logic [31:0] mem4(input logic [7:0] a);
    return {dut.mem_q[a + 8'd3], dut.mem_q[a + 8'd2], dut.mem_q[a + 8'd1], dut.mem_q[a]};
  endfunction
  always @(negedge clk) begin
    if (rst_n && (bus.Enable_memory || bus.Enable_IO1 || bus.Enable_IO2) && !bus.read_memory && !bus.read_io) begin
      got = '{dev: bus.Enable_IO2 ? 2'd2 : bus.Enable_IO1 ? 2'd1 : 2'd0, ab: bus.AB, db: bus.DB};
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %0h expected no write", got);
      end else begin
        e = exp_q.pop_front();
        chk("sb_write", 32'(got), 32'(e));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    bus.mode_processor = 3'b111;
    bus.mode_io = 2'b11;
    bus.mode_io2 = 2'b11;
    cyc(2);
    chk("rst_A", bus.A, 8'h05);
    chk("rst_B", bus.B, 8'h03);
    chk("rst_C", bus.C, 8'h00);
    chk("rst_hs", {bus.HREQ, bus.HACK, bus.cs}, 0);
    chk("rst_bus", {bus.DB, bus.AB}, 0);
    rst_n = 1'b1;
    cyc(1);
    // IO1 request wins over simultaneous processor 110, which is dropped
    bus.mode_io = 2'b00;
    bus.mode_processor = 3'b110;
    push(2'd0, 8'h30, 8'hA0);
    cyc(1);
    chk("prio_dreq1", bus.DREQ1, 1);
    chk("prio_src_io", bus.read_io, 0);
    cyc(2);
    wait_done("prio_len", 9);
    chk("prio_dack1", dack1_seen, 1);
    cyc(1);
    bus.mode_io = 2'b11;
    bus.mode_processor = 3'b111;
    cyc(3);
    chk("prio_dropped", bus.HREQ, 0);
    chk("prio_mem", mem4(8'h30), 32'hA3A2A1A0);
    // processor 110: mem 10h -> IO1 index 0
    bus.mode_processor = 3'b110;
    push(2'd1, 8'h00, 8'h10);
    cyc(1);
    chk("p110_cs", bus.cs, 1);
    chk("p110_hreq0", bus.HREQ, 0);
    cyc(1);
    chk("p110_cs_off", bus.cs, 0);
    chk("p110_hreq", {bus.HREQ, bus.HACK}, 2'b10);
    cyc(1);
    chk("p110_hack", bus.HACK, 1);
    cyc(1);
    bus.mode_processor = 3'b111;
    wait_done("p110_len", 8);
    chk("p110_hack_late", bus.HACK, 1);
    cyc(1);
    chk("p110_hack_off", bus.HACK, 0);
    chk("p110_wc", bus.word_count, 4);
    chk("p110_cnt", bus.cnt_reg, 0);
    chk("p110_dack1", dack1_seen, 0);
    chk("p110_buf1", {dut.buf1_q[3], dut.buf1_q[2], dut.buf1_q[1], dut.buf1_q[0]}, 32'h13121110);
    cyc(1);
    // processor 100: mem 10h -> mem 40h
    bus.mode_processor = 3'b100;
    push(2'd0, 8'h40, 8'h10);
    cyc(1);
    chk("m2m_flag", bus.MemToMem, 1);
    bus.mode_processor = 3'b111;
    cyc(2);
    wait_done("m2m_len", 9);
    chk("m2m_rdio", rdio_seen, 0);
    chk("m2m_mem", mem4(8'h40), 32'h13121110);
    chk("m2m_data", bus.data, 8'h13);
    cyc(2);
    chk("m2m_clear", bus.MemToMem, 0);
    // IO2 request 00: IO2 index 0 -> mem 38h
    bus.mode_io2 = 2'b00;
    push(2'd0, 8'h38, 8'hB0);
    cyc(1);
    chk("io2_dreq", bus.DREQ2, 1);
    bus.mode_io2 = 2'b11;
    cyc(2);
    wait_done("io2_len", 9);
    chk("io2_dack", dack2_seen, 1);
    chk("io2_mem", mem4(8'h38), 32'hB3B2B1B0);
    cyc(2);
    // ALU, then C holding across an IO2 mem->IO transfer
    bus.mode_processor = 3'b000;
    cyc(1);
    chk("alu_add", bus.C, 8'h08);
    bus.mode_processor = 3'b001;
    cyc(1);
    chk("alu_sub", bus.C, 8'h02);
    bus.mode_processor = 3'b010;
    cyc(1);
    chk("alu_and", bus.C, 8'h01);
    bus.mode_processor = 3'b011;
    cyc(1);
    chk("alu_or", bus.C, 8'h07);
    bus.mode_processor = 3'b111;
    bus.mode_io2 = 2'b01;
    push(2'd2, 8'h00, 8'h58);
    cyc(1);
    bus.mode_io2 = 2'b11;
    cyc(2);
    bus.mode_processor = 3'b000;
    wait_done("hold_len", 9);
    chk("alu_hold", bus.C, 8'h07);
    cyc(2);
    chk("alu_resume", bus.C, 8'h08);
    chk("io2_buf", {dut.buf2_q[3], dut.buf2_q[2], dut.buf2_q[1], dut.buf2_q[0]}, 32'h5B5A5958);
    bus.mode_processor = 3'b111;
    cyc(2);
    // reset in the middle of an IO1 mem->IO transfer
    bus.mode_io = 2'b01;
    exp_q.push_back('{dev: 2'd1, ab: 8'h00, db: 8'h50});
    cyc(1);
    bus.mode_io = 2'b11;
    cyc(6);
    chk("abort_pre", {bus.HREQ, bus.HACK, bus.DACK1}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("abort_hs", {bus.HREQ, bus.HACK, bus.DACK1, bus.DREQ1}, 0);
    chk("abort_bus", {bus.AB, bus.DB}, 0);
    chk("abort_buf1", dut.buf1_q[0], 8'hA0);
    chk("abort_mem", dut.mem_q[8'h40], 8'h40);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    bus.mode_processor = 3'b100;
    push(2'd0, 8'h40, 8'h10);
    cyc(1);
    bus.mode_processor = 3'b111;
    cyc(2);
    wait_done("fresh_len", 9);
    chk("fresh_mem", mem4(8'h40), 32'h13121110);
    chk("fresh_wc", bus.word_count, 4);
    cyc(2);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
